// File: rtl/packet_framer.sv
// rtl/packet_framer.sv - buffers UART bytes and frames them as SYNC, payload, CRC-8 for interfpga_send
module packet_framer #(
  parameter int         PAYLOAD_LEN = 16,
  parameter int         FIFO_AW     = 4,
  parameter logic [7:0] SYNC_BYTE   = 8'hA5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic [7:0]       out_data,
  output logic             out_send,
  input  logic             out_busy,
  output logic [FIFO_AW:0] fifo_level,
  output logic             overflow,
  output logic             frame_active,
  output logic [7:0]       last_crc,
  output logic [7:0]       pkt_count
);

  localparam int                 DEPTH   = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]   FULL    = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0]   LVL_ONE = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE = (FIFO_AW)'(1);
  localparam logic [7:0]         PLEN    = 8'(PAYLOAD_LEN);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE, NEXT} state_t;

  state_t             state, state_n;
  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic               push, pop;
  logic [7:0]         idx, idx_n, crc, crc_n;
  logic [7:0]         out_data_n, last_crc_n, pkt_count_n;
  logic               crc_sent, crc_sent_n, frame_active_n, out_send_n;

  function automatic logic [7:0] crc8_fold(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++)
      r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    return r;
  endfunction

  // Fullness is judged on the pre-edge level, so a same-cycle pop never rescues a byte.
  assign push = in_valid && (fifo_level != FULL);

  always_comb begin
    state_n        = state;
    idx_n          = idx;
    crc_n          = crc;
    crc_sent_n     = crc_sent;
    out_data_n     = out_data;
    last_crc_n     = last_crc;
    pkt_count_n    = pkt_count;
    frame_active_n = frame_active;
    out_send_n     = 1'b0;
    pop            = 1'b0;
    case (state)
      IDLE: begin
        if (fifo_level != '0) begin
          out_data_n     = SYNC_BYTE;
          idx_n          = '0;
          crc_n          = '0;
          crc_sent_n     = 1'b0;
          frame_active_n = 1'b1;
          state_n        = ISSUE;
        end
      end
      ISSUE: begin
        if (!out_busy) begin
          out_send_n = 1'b1;
          state_n    = WAIT_ACK;
        end
      end
      WAIT_ACK:  if (out_busy)  state_n = WAIT_DONE;
      WAIT_DONE: if (!out_busy) state_n = NEXT;
      NEXT: begin
        if (idx != PLEN) begin
          if (fifo_level != '0) begin
            pop        = 1'b1;
            out_data_n = mem[rd_ptr];
            crc_n      = crc8_fold(crc, mem[rd_ptr]);
            idx_n      = idx + 8'd1;
            state_n    = ISSUE;
          end
        end else if (!crc_sent) begin
          out_data_n = crc;
          crc_sent_n = 1'b1;
          state_n    = ISSUE;
        end else begin
          last_crc_n     = crc;
          pkt_count_n    = pkt_count + 8'd1;
          frame_active_n = 1'b0;
          state_n        = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      idx          <= '0;
      crc          <= '0;
      crc_sent     <= 1'b0;
      out_data     <= '0;
      out_send     <= 1'b0;
      last_crc     <= '0;
      pkt_count    <= '0;
      frame_active <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_level   <= '0;
      overflow     <= 1'b0;
    end else begin
      state        <= state_n;
      idx          <= idx_n;
      crc          <= crc_n;
      crc_sent     <= crc_sent_n;
      out_data     <= out_data_n;
      out_send     <= out_send_n;
      last_crc     <= last_crc_n;
      pkt_count    <= pkt_count_n;
      frame_active <= frame_active_n;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LVL_ONE;
        2'b01:   fifo_level <= fifo_level - LVL_ONE;
        default: fifo_level <= fifo_level;
      endcase
      if (in_valid && !push) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) mem[wr_ptr] <= in_data;
  end

endmodule

// File: tb/tb_packet_framer.sv
// tb/tb_packet_framer.sv - randomized self-checking bench for packet_framer
module tb_packet_framer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic [7:0] in_data [2];
  logic       in_valid [2];
  logic       out_busy [2];
  logic [7:0] out_data [2];
  logic       out_send [2];
  logic [4:0] fifo_level [2];
  logic       overflow [2];
  logic       frame_active [2];
  logic [7:0] last_crc [2];
  logic [7:0] pkt_count [2];

  logic       force_busy [2];
  bit         rand_busy = 1'b0;
  int         bdel [2];
  int         bhi [2];
  int         viol [2];
  logic [7:0] act_q [2][$];
  logic [7:0] exp_q [2][$];
  int         errors = 0;
  int         checks = 0;

  packet_framer #(.PAYLOAD_LEN(9)) dut9 (
    .clk(clk), .reset(reset), .in_data(in_data[0]), .in_valid(in_valid[0]),
    .out_data(out_data[0]), .out_send(out_send[0]), .out_busy(out_busy[0]),
    .fifo_level(fifo_level[0]), .overflow(overflow[0]), .frame_active(frame_active[0]),
    .last_crc(last_crc[0]), .pkt_count(pkt_count[0])
  );

  packet_framer #(.PAYLOAD_LEN(1)) dut1 (
    .clk(clk), .reset(reset), .in_data(in_data[1]), .in_valid(in_valid[1]),
    .out_data(out_data[1]), .out_send(out_send[1]), .out_busy(out_busy[1]),
    .fifo_level(fifo_level[1]), .overflow(overflow[1]), .frame_active(frame_active[1]),
    .last_crc(last_crc[1]), .pkt_count(pkt_count[1])
  );

  // Receiver-side model of interfpga_send: records each byte and answers with a busy pulse.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        bdel[k] = 0;
        bhi[k]  = 0;
        out_busy[k] = force_busy[k];
      end else begin
        if (out_send[k] === 1'b1) begin
          if (out_busy[k] === 1'b1) viol[k]++;
          act_q[k].push_back(out_data[k]);
          bdel[k] = rand_busy ? $urandom_range(1, 3) : 2;
          bhi[k]  = rand_busy ? $urandom_range(1, 12) : 10;
        end else if (bdel[k] > 0) bdel[k]--;
        else if (bhi[k] > 0) bhi[k]--;
        out_busy[k] = force_busy[k] | (bdel[k] == 0 && bhi[k] > 0);
      end
    end
  end

  function automatic logic [7:0] ref_crc(input logic [7:0] b[$]);
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    foreach (b[i])
      for (int j = 7; j >= 0; j--) begin
        fb = c[7] ^ b[i][j];
        c  = {c[6:0], 1'b0};
        if (fb) c = c ^ 8'h07;
      end
    return c;
  endfunction

  task automatic add_frames(input int k, input logic [7:0] b[$], input int plen);
    for (int f = 0; f < b.size() / plen; f++) begin
      logic [7:0] fr[$];
      fr = {};
      for (int j = 0; j < plen; j++) fr.push_back(b[f * plen + j]);
      exp_q[k].push_back(8'hA5);
      foreach (fr[j]) exp_q[k].push_back(fr[j]);
      exp_q[k].push_back(ref_crc(fr));
    end
  endtask

  task automatic push_byte(input int k, input logic [7:0] b);
    in_data[k]  = b;
    in_valid[k] = 1'b1;
    @(negedge clk);
    in_valid[k] = 1'b0;
  endtask

  task automatic clear_q(input int k);
    act_q[k] = {};
    exp_q[k] = {};
  endtask

  task automatic wait_count(input int k, input int n, input string name);
    int t = 0;
    while (act_q[k].size() < n && t < 3000) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (act_q[k].size() < n) begin
      errors++;
      $display("FAIL %s_timeout got %0d bytes want %0d", name, act_q[k].size(), n);
    end
  endtask

  task automatic wait_drain(input int k, input string name);
    int t = 0;
    while (act_q[k].size() < exp_q[k].size() && t < 5000) begin
      @(negedge clk);
      t++;
    end
    repeat (40) @(negedge clk);
    checks++;
    if (act_q[k].size() != exp_q[k].size()) begin
      errors++;
      $display("FAIL %s_len got %0d want %0d", name, act_q[k].size(), exp_q[k].size());
    end
    for (int i = 0; i < act_q[k].size() && i < exp_q[k].size(); i++) begin
      checks++;
      if (act_q[k][i] !== exp_q[k][i]) begin
        errors++;
        $display("FAIL %s_byte[%0d] got %h want %h", name, i, act_q[k][i], exp_q[k][i]);
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      for (int k = 0; k < 2; k++) begin
        in_data[k]    = 8'($urandom);
        in_valid[k]   = 1'($urandom);
        force_busy[k] = 1'($urandom);
      end
      @(negedge clk);
    end
    for (int k = 0; k < 2; k++) begin
      checks += 7;
      if (out_send[k] !== 1'b0) begin errors++; $display("FAIL reset_out_send[%0d] got %b want 0", k, out_send[k]); end
      if (out_data[k] !== 8'h00) begin errors++; $display("FAIL reset_out_data[%0d] got %h want 00", k, out_data[k]); end
      if (fifo_level[k] !== 5'd0) begin errors++; $display("FAIL reset_fifo_level[%0d] got %0d want 0", k, fifo_level[k]); end
      if (overflow[k] !== 1'b0) begin errors++; $display("FAIL reset_overflow[%0d] got %b want 0", k, overflow[k]); end
      if (pkt_count[k] !== 8'h00) begin errors++; $display("FAIL reset_pkt_count[%0d] got %0d want 0", k, pkt_count[k]); end
      if (last_crc[k] !== 8'h00) begin errors++; $display("FAIL reset_last_crc[%0d] got %h want 00", k, last_crc[k]); end
      if (frame_active[k] !== 1'b0) begin errors++; $display("FAIL reset_frame_active[%0d] got %b want 0", k, frame_active[k]); end
      in_valid[k]   = 1'b0;
      force_busy[k] = 1'b0;
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    clear_q(0);
    clear_q(1);
  endtask

  task automatic test_golden();
    logic [7:0] g[$];
    int t = 0;
    g = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    rand_busy = 1'b0;
    clear_q(0);
    exp_q[0] = '{8'hA5, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'hF4};
    foreach (g[i]) push_byte(0, g[i]);
    wait_drain(0, "golden");
    while (frame_active[0] !== 1'b0 && t < 500) begin @(negedge clk); t++; end
    checks += 3;
    if (last_crc[0] !== 8'hF4) begin errors++; $display("FAIL golden_last_crc got %h want f4", last_crc[0]); end
    if (pkt_count[0] !== 8'd1) begin errors++; $display("FAIL golden_pkt_count got %0d want 1", pkt_count[0]); end
    if (frame_active[0] !== 1'b0) begin errors++; $display("FAIL golden_frame_active got %b want 0", frame_active[0]); end
  endtask

  task automatic test_backpressure();
    logic [7:0] b[$];
    logic [7:0] held;
    int sent0;
    int bad = 0;
    clear_q(0);
    for (int i = 0; i < 9; i++) b.push_back(8'($urandom));
    add_frames(0, b, 9);
    foreach (b[i]) push_byte(0, b[i]);
    wait_count(0, 4, "bp_start");
    force_busy[0] = 1'b1;
    repeat (3) @(negedge clk);
    held  = out_data[0];
    sent0 = act_q[0].size();
    repeat (47) begin
      @(negedge clk);
      if (out_data[0] !== held) bad++;
    end
    checks += 2;
    if (act_q[0].size() != sent0) begin errors++; $display("FAIL bp_sends got %0d want %0d", act_q[0].size(), sent0); end
    if (bad != 0) begin errors++; $display("FAIL bp_data_stable got %0d changes want 0", bad); end
    force_busy[0] = 1'b0;
    wait_drain(0, "bp");
  endtask

  task automatic test_overflow();
    logic [7:0] b[$];
    logic [7:0] kept[$];
    clear_q(0);
    for (int i = 0; i < 20; i++) b.push_back(8'($urandom));
    for (int i = 0; i < 20; i++) begin
      if (i == 4) force_busy[0] = 1'b1;
      push_byte(0, b[i]);
    end
    checks += 3;
    if (fifo_level[0] !== 5'd16) begin errors++; $display("FAIL ovf_level got %0d want 16", fifo_level[0]); end
    if (overflow[0] !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", overflow[0]); end
    if (act_q[0].size() != 1) begin errors++; $display("FAIL ovf_sends got %0d want 1", act_q[0].size()); end
    force_busy[0] = 1'b0;
    repeat (60) @(negedge clk);
    for (int i = 0; i < 16; i++) kept.push_back(b[i]);
    kept.push_back(8'h5A);
    kept.push_back(8'hC3);
    push_byte(0, 8'h5A);
    push_byte(0, 8'hC3);
    add_frames(0, kept, 9);
    wait_drain(0, "ovf");
    checks++;
    if (overflow[0] !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", overflow[0]); end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] b[$];
    clear_q(0);
    for (int i = 0; i < 9; i++) push_byte(0, 8'($urandom));
    wait_count(0, 4, "rst_mid_start");
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks += 7;
    if (out_send[0] !== 1'b0) begin errors++; $display("FAIL rst_mid_out_send got %b want 0", out_send[0]); end
    if (out_data[0] !== 8'h00) begin errors++; $display("FAIL rst_mid_out_data got %h want 00", out_data[0]); end
    if (fifo_level[0] !== 5'd0) begin errors++; $display("FAIL rst_mid_level got %0d want 0", fifo_level[0]); end
    if (overflow[0] !== 1'b0) begin errors++; $display("FAIL rst_mid_overflow got %b want 0", overflow[0]); end
    if (pkt_count[0] !== 8'd0) begin errors++; $display("FAIL rst_mid_pkt_count got %0d want 0", pkt_count[0]); end
    if (last_crc[0] !== 8'h00) begin errors++; $display("FAIL rst_mid_last_crc got %h want 00", last_crc[0]); end
    if (frame_active[0] !== 1'b0) begin errors++; $display("FAIL rst_mid_frame_active got %b want 0", frame_active[0]); end
    reset = 1'b0;
    @(negedge clk);
    clear_q(0);
    for (int i = 0; i < 9; i++) b.push_back(8'($urandom));
    add_frames(0, b, 9);
    foreach (b[i]) push_byte(0, b[i]);
    wait_drain(0, "rst_mid");
    checks += 2;
    if (pkt_count[0] !== 8'd1) begin errors++; $display("FAIL rst_mid_new_count got %0d want 1", pkt_count[0]); end
    if (last_crc[0] !== ref_crc(b)) begin errors++; $display("FAIL rst_mid_new_crc got %h want %h", last_crc[0], ref_crc(b)); end
  endtask

  task automatic test_random_traffic();
    logic [7:0] b[$];
    logic [7:0] tail[$];
    rand_busy = 1'b1;
    clear_q(0);
    for (int i = 0; i < 27; i++) b.push_back(8'($urandom));
    add_frames(0, b, 9);
    foreach (b[i]) begin
      push_byte(0, b[i]);
      repeat ($urandom_range(8, 14)) @(negedge clk);
    end
    wait_drain(0, "random");
    for (int i = 18; i < 27; i++) tail.push_back(b[i]);
    checks += 3;
    if (pkt_count[0] !== 8'd4) begin errors++; $display("FAIL random_pkt_count got %0d want 4", pkt_count[0]); end
    if (last_crc[0] !== ref_crc(tail)) begin errors++; $display("FAIL random_last_crc got %h want %h", last_crc[0], ref_crc(tail)); end
    if (overflow[0] !== 1'b0) begin errors++; $display("FAIL random_overflow got %b want 0", overflow[0]); end
    rand_busy = 1'b0;
  endtask

  task automatic test_starve_wrap();
    clear_q(1);
    for (int f = 0; f < 256; f++) begin
      repeat (100) @(negedge clk);
      if (f == 1) begin
        checks++;
        if (pkt_count[1] !== 8'd1) begin errors++; $display("FAIL wrap_first_count got %0d want 1", pkt_count[1]); end
      end
      push_byte(1, 8'h01);
      exp_q[1].push_back(8'hA5);
      exp_q[1].push_back(8'h01);
      exp_q[1].push_back(8'h07);
    end
    wait_drain(1, "wrap");
    checks += 3;
    if (pkt_count[1] !== 8'd0) begin errors++; $display("FAIL wrap_pkt_count got %0d want 0", pkt_count[1]); end
    if (last_crc[1] !== 8'h07) begin errors++; $display("FAIL wrap_last_crc got %h want 07", last_crc[1]); end
    if (frame_active[1] !== 1'b0) begin errors++; $display("FAIL wrap_frame_active got %b want 0", frame_active[1]); end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      in_data[k]    = 8'h00;
      in_valid[k]   = 1'b0;
      force_busy[k] = 1'b0;
      viol[k]       = 0;
    end
    @(negedge clk);
    test_reset();
    test_golden();
    test_backpressure();
    test_overflow();
    test_reset_midframe();
    test_random_traffic();
    test_starve_wrap();
    checks++;
    if (viol[0] + viol[1] != 0) begin
      errors++;
      $display("FAIL send_while_busy got %0d want 0", viol[0] + viol[1]);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
